// File: rtl/mmio_initiator.sv
// -----------------------------------------------------------------------------
// mmio_initiator
//   CPU-side master for the MMIO bus. Accepts one load/store from the memory
//   stage, drives a read or write strobe with address/data held until the
//   device signals completion, then returns a one-cycle response carrying
//   read data or a bus error (timeout or misaligned address). The pipeline is
//   stalled (busy) from the cycle after acceptance until the response cycle.
//
// Ports
//   sys_clk, rst        clock (rising edge) and synchronous active-high reset
//   req_valid/_write    CPU request handshake, accepted when req_ready=1
//   req_addr/_wdata     byte address (word aligned) and store data
//   req_ready, busy     IDLE indicator and pipeline stall (WAIT or RESP)
//   resp_valid/_rdata   one-cycle response pulse and load data / ERR_RDATA
//   resp_err            response is a bus error
//   err_count           saturating error counter since reset
//   mmio_read/_write    bus strobes, never high together
//   mmio_addr/_write_data  latched request address and store data
//   mmio_done           device completion, only looked at in WAIT
//   mmio_read_data      device read data, valid with mmio_done
// -----------------------------------------------------------------------------
module mmio_initiator #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
  input  logic        sys_clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        busy,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [7:0]  err_count,
  output logic        mmio_read,
  output logic        mmio_write,
  output logic [31:0] mmio_addr,
  output logic [31:0] mmio_write_data,
  input  logic        mmio_done,
  input  logic [31:0] mmio_read_data
);

  localparam int unsigned   CW       = $clog2(TIMEOUT_CYCLES + 1);
  // Last WAIT cycle index before the access is declared timed out.
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rd_q, rd_d;
  logic          wr_q, wr_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          rvalid_q, rvalid_d;
  logic          rerr_q, rerr_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [7:0]    errcnt_q, errcnt_d;
  logic          err_evt;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rd_d     = rd_q;
    wr_d     = wr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    // Response fields are pulses: they clear unless set this cycle.
    rvalid_d = 1'b0;
    rerr_d   = 1'b0;
    rdata_d  = 32'h0;
    err_evt  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          if (req_addr[1:0] == 2'b00) begin
            addr_d  = req_addr;
            wdata_d = req_wdata;
            wr_d    = req_write;
            rd_d    = ~req_write;
            cnt_d   = '0;
            state_d = S_WAIT;
          end else begin
            // Misaligned: no bus cycle at all, straight to an error response.
            rvalid_d = 1'b1;
            rerr_d   = 1'b1;
            rdata_d  = ERR_RDATA;
            err_evt  = 1'b1;
            state_d  = S_RESP;
          end
        end
      end

      S_WAIT: begin
        cnt_d = cnt_q + CW'(1);
        // Completion takes priority over a timeout landing in the same cycle.
        if (mmio_done) begin
          rd_d     = 1'b0;
          wr_d     = 1'b0;
          rvalid_d = 1'b1;
          rdata_d  = rd_q ? mmio_read_data : 32'h0;
          state_d  = S_RESP;
        end else if (cnt_q == CNT_LAST) begin
          rd_d     = 1'b0;
          wr_d     = 1'b0;
          rvalid_d = 1'b1;
          rerr_d   = 1'b1;
          rdata_d  = ERR_RDATA;
          err_evt  = 1'b1;
          state_d  = S_RESP;
        end
      end

      S_RESP: begin
        // Strobes are already low here, giving a one-cycle bus turnaround.
        state_d = S_IDLE;
      end

      default: begin
        rd_d    = 1'b0;
        wr_d    = 1'b0;
        state_d = S_IDLE;
      end
    endcase

    errcnt_d = (err_evt && (errcnt_q != 8'hFF)) ? errcnt_q + 8'd1 : errcnt_q;
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
      rvalid_q <= 1'b0;
      rerr_q   <= 1'b0;
      rdata_q  <= 32'h0;
      errcnt_q <= 8'h0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rvalid_q <= rvalid_d;
      rerr_q   <= rerr_d;
      rdata_q  <= rdata_d;
      errcnt_q <= errcnt_d;
    end
  end

  assign req_ready       = (state_q == S_IDLE);
  assign busy            = (state_q != S_IDLE);
  assign resp_valid      = rvalid_q;
  assign resp_err        = rerr_q;
  assign resp_rdata      = rdata_q;
  assign err_count       = errcnt_q;
  assign mmio_read       = rd_q;
  assign mmio_write      = wr_q;
  assign mmio_addr       = addr_q;
  assign mmio_write_data = wdata_q;

endmodule

// File: tb/tb_mmio_initiator.sv
module tb_mmio_initiator;

  logic        sys_clk;
  logic        rst;
  logic        req_valid;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_ready;
  logic        busy;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [7:0]  err_count;
  logic        mmio_read;
  logic        mmio_write;
  logic [31:0] mmio_addr;
  logic [31:0] mmio_write_data;
  logic        mmio_done;
  logic [31:0] mmio_read_data;

  mmio_initiator #(
    .TIMEOUT_CYCLES(4),
    .ERR_RDATA     (32'hDEAD_BEEF)
  ) dut (
    .sys_clk        (sys_clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_write      (req_write),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .req_ready      (req_ready),
    .busy           (busy),
    .resp_valid     (resp_valid),
    .resp_rdata     (resp_rdata),
    .resp_err       (resp_err),
    .err_count      (err_count),
    .mmio_read      (mmio_read),
    .mmio_write     (mmio_write),
    .mmio_addr      (mmio_addr),
    .mmio_write_data(mmio_write_data),
    .mmio_done      (mmio_done),
    .mmio_read_data (mmio_read_data)
  );

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] done_at;   // WAIT cycle (1-based) carrying mmio_done; 0 = never
    logic [31:0] devdata;
    logic [31:0] exp_strobes;
    logic [31:0] exp_resp_cyc;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[8];
  int   ncmp;
  int   nfail;
  int   errs_exp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int          strobes;
    int          resp_cyc;
    int          viol;
    bit          seen;
    logic [31:0] rd;
    logic        re;
    logic [7:0]  ec;
    strobes  = 0;
    resp_cyc = 0;
    viol     = 0;
    seen     = 1'b0;
    rd       = 32'h0;
    re       = 1'b0;
    ec       = 8'h0;
    req_valid = 1'b1;
    req_write = v.write;
    req_addr  = v.addr;
    req_wdata = v.wdata;
    mmio_done = 1'b0;
    step();
    req_valid = 1'b0;
    req_addr  = 32'h0;
    req_wdata = 32'h0;
    for (int cyc = 1; cyc <= 20 && !seen; cyc++) begin
      if (mmio_read || mmio_write) begin
        strobes++;
        if (mmio_addr !== v.addr || mmio_write_data !== v.wdata ||
            mmio_write !== v.write || mmio_read !== !v.write)
          viol++;
      end
      if (busy !== 1'b1 || req_ready !== 1'b0) viol++;
      if (resp_valid === 1'b1) begin
        seen      = 1'b1;
        resp_cyc  = cyc;
        rd        = resp_rdata;
        re        = resp_err;
        ec        = err_count;
        mmio_done = 1'b0;
      end else begin
        mmio_done = (mmio_read || mmio_write) && (v.done_at != 0) &&
                    (32'(strobes) == v.done_at);
        mmio_read_data = mmio_done ? v.devdata : 32'h0BAD_0BAD;
      end
      step();
    end
    mmio_done = 1'b0;
    if (v.exp_err) errs_exp++;
    chk($sformatf("v%0d_strobe_cycles", idx), 32'(strobes), v.exp_strobes);
    chk($sformatf("v%0d_resp_cycle", idx), 32'(resp_cyc), v.exp_resp_cyc);
    chk($sformatf("v%0d_resp_rdata", idx), rd, v.exp_rdata);
    chk($sformatf("v%0d_resp_err", idx), 32'(re), 32'(v.exp_err));
    chk($sformatf("v%0d_err_count", idx), 32'(ec), 32'(errs_exp));
    chk($sformatf("v%0d_stable_violations", idx), 32'(viol), 32'd0);
    chk($sformatf("v%0d_post_ready", idx), {30'h0, req_ready, busy}, 32'h2);
    chk($sformatf("v%0d_post_resp_clear", idx),
        {resp_valid, resp_err, resp_rdata[29:0]}, 32'h0);
  endtask

  initial begin
    int nresp;
    int adj;
    int both;
    int bad;
    int strb;
    int nerr;
    logic prev_rd;

    ncmp     = 0;
    nfail    = 0;
    errs_exp = 0;

    //            wr    addr          wdata         done  devdata       strb  rcyc  rdata         err
    vecs[0] = '{1'b0, 32'hFFFF_FC00, 32'h0000_0000, 32'd2, 32'h00A5_5A00, 32'd2, 32'd3, 32'h00A5_5A00, 1'b0};
    vecs[1] = '{1'b1, 32'hFFFF_FC60, 32'h0000_00FF, 32'd1, 32'h1234_5678, 32'd1, 32'd2, 32'h0000_0000, 1'b0};
    vecs[2] = '{1'b0, 32'hFFFF_FC04, 32'h0000_0000, 32'd0, 32'h0000_0000, 32'd4, 32'd5, 32'hDEAD_BEEF, 1'b1};
    vecs[3] = '{1'b0, 32'hFFFF_FC02, 32'h0000_0000, 32'd0, 32'h0000_0000, 32'd0, 32'd1, 32'hDEAD_BEEF, 1'b1};
    vecs[4] = '{1'b1, 32'hFFFF_FC08, 32'hCAFE_F00D, 32'd0, 32'h0000_0000, 32'd4, 32'd5, 32'hDEAD_BEEF, 1'b1};
    vecs[5] = '{1'b0, 32'hFFFF_FC0C, 32'h0000_0000, 32'd4, 32'h1357_9BDF, 32'd4, 32'd5, 32'h1357_9BDF, 1'b0};
    vecs[6] = '{1'b1, 32'hFFFF_FC61, 32'h5555_AAAA, 32'd0, 32'h0000_0000, 32'd0, 32'd1, 32'hDEAD_BEEF, 1'b1};
    vecs[7] = '{1'b0, 32'h0000_1000, 32'h0000_0000, 32'd3, 32'h8000_0001, 32'd3, 32'd4, 32'h8000_0001, 1'b0};

    rst            = 1'b1;
    req_valid      = 1'b0;
    req_write      = 1'b0;
    req_addr       = 32'h0;
    req_wdata      = 32'h0;
    mmio_done      = 1'b0;
    mmio_read_data = 32'h0;
    step();
    step();
    step();

    // Reset state
    chk("rst_ready_busy", {30'h0, req_ready, busy}, 32'h2);
    chk("rst_strobes", {30'h0, mmio_read, mmio_write}, 32'h0);
    chk("rst_resp", {30'h0, resp_valid, resp_err}, 32'h0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    chk("rst_err_count", 32'(err_count), 32'h0);
    chk("rst_mmio_addr", mmio_addr, 32'h0);
    chk("rst_mmio_wdata", mmio_write_data, 32'h0);
    rst = 1'b0;
    step();

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    // Reset in the 2nd WAIT cycle of a store
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 32'hFFFF_FC10;
    req_wdata = 32'h0000_AA55;
    step();
    req_valid = 1'b0;
    chk("midrst_wait1_write", 32'(mmio_write), 32'h1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    errs_exp = 0;
    chk("midrst_strobes", {30'h0, mmio_read, mmio_write}, 32'h0);
    chk("midrst_ready_busy", {30'h0, req_ready, busy}, 32'h2);
    chk("midrst_err_count", 32'(err_count), 32'h0);
    nresp = 0;
    for (int i = 0; i < 8; i++) begin
      if (resp_valid === 1'b1) nresp++;
      step();
    end
    chk("midrst_no_resp", 32'(nresp), 32'h0);

    // Back-to-back loads with mmio_done held high
    mmio_done      = 1'b1;
    mmio_read_data = 32'h0F0F_1234;
    req_valid      = 1'b1;
    req_write      = 1'b0;
    req_addr       = 32'hFFFF_FC20;
    nresp   = 0;
    adj     = 0;
    both    = 0;
    bad     = 0;
    prev_rd = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (mmio_read && prev_rd) adj++;
      if (mmio_read && mmio_write) both++;
      if (resp_valid === 1'b1) begin
        nresp++;
        if (resp_rdata !== 32'h0F0F_1234 || resp_err !== 1'b0) bad++;
      end
      prev_rd = mmio_read;
    end
    req_valid = 1'b0;
    for (int i = 0; i < 5 && !(req_ready === 1'b1); i++) step();
    mmio_done = 1'b0;
    chk("b2b_resp_count", 32'(nresp), 32'd10);
    chk("b2b_no_turnaround", 32'(adj), 32'd0);
    chk("b2b_both_strobes", 32'(both), 32'd0);
    chk("b2b_bad_resp", 32'(bad), 32'd0);
    chk("b2b_idle_after", {30'h0, req_ready, busy}, 32'h2);

    // 300 misaligned errors: counter saturates
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 32'hFFFF_FC03;
    strb = 0;
    nerr = 0;
    for (int i = 0; i < 700 && nerr < 300; i++) begin
      step();
      if (mmio_read || mmio_write) strb++;
      if (resp_valid === 1'b1 && resp_err === 1'b1) begin
        nerr++;
        if (nerr == 254) chk("sat_at_254", 32'(err_count), 32'd254);
        if (nerr == 255) chk("sat_at_255", 32'(err_count), 32'd255);
        if (nerr == 256) chk("sat_at_256", 32'(err_count), 32'd255);
      end
    end
    req_valid = 1'b0;
    step();
    step();
    chk("sat_error_count", 32'(nerr), 32'd300);
    chk("sat_no_strobes", 32'(strb), 32'd0);
    chk("sat_final", 32'(err_count), 32'h0000_00FF);

    $display("== %0d vectors applied, %0d miscompares ==", ncmp, nfail);
    $finish;
  end

endmodule
